// File: rtl/win_banner_overlay_pkg.sv
// Shared display definitions for the win banner overlay: sprite ROM geometry,
// raster coordinate width, palette constants and the controller state encoding.
package win_banner_overlay_pkg;

    localparam int CW    = 11;
    localparam int SPR_W = 64;
    localparam int SPR_H = 48;

    localparam logic [15:0] C_BLACK  = 16'h0000;
    localparam logic [15:0] C_GREEN  = 16'h07E0;
    localparam logic [15:0] C_YELLOW = 16'hFFE0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2
    } banner_state_e;

    // Window extent along one axis for a given sprite size and upscale.
    function automatic logic [CW-1:0] win_extent(input int size, input int scale_log2);
        return CW'(size << scale_log2);
    endfunction

endpackage

// File: rtl/win_banner_overlay_banner_ctrl_fsm.sv
// Frame-synchronous show/hide/blink controller: state register, blink counter,
// visibility toggle and per-frame origin latch.
module banner_ctrl_fsm
    import win_banner_overlay_pkg::*;
#(
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          show,
    input  logic          frame_start,
    input  logic [CW-1:0] org_x,
    input  logic [CW-1:0] org_y,
    output logic          active,
    output logic          visible,
    output logic [CW-1:0] ox,
    output logic [CW-1:0] oy
);

    localparam logic [7:0] BF_LAST = 8'(BLINK_FRAMES - 1);

    banner_state_e state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          vis_q, vis_d;
    logic [CW-1:0] ox_q, ox_d;
    logic [CW-1:0] oy_q, oy_d;

    // Next-state, blink counter and origin latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vis_d   = vis_q;
        ox_d    = ox_q;
        oy_d    = oy_q;

        if (frame_start) begin
            ox_d = org_x;
            oy_d = org_y;
        end else begin
            ox_d = ox_q;
            oy_d = oy_q;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = 8'd0;
                vis_d = 1'b1;
                if (show) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                cnt_d = 8'd0;
                vis_d = 1'b1;
                // Withdrawal of show wins over a coincident frame_start.
                if (!show) begin
                    state_d = ST_IDLE;
                end else if (frame_start) begin
                    state_d = ST_ACTIVE;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_ACTIVE: begin
                if (frame_start) begin
                    if (!show) begin
                        state_d = ST_IDLE;
                        cnt_d   = 8'd0;
                        vis_d   = 1'b1;
                    end else if (BLINK_FRAMES != 0) begin
                        if (cnt_q == BF_LAST) begin
                            cnt_d = 8'd0;
                            vis_d = ~vis_q;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else begin
                        cnt_d = 8'd0;
                        vis_d = 1'b1;
                    end
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
                vis_d   = 1'b1;
            end
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            vis_q   <= 1'b1;
            ox_q    <= '0;
            oy_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vis_q   <= vis_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
        end
    end

    assign active  = (state_q == ST_ACTIVE);
    assign visible = vis_q;
    assign ox      = ox_q;
    assign oy      = oy_q;

endmodule

// File: rtl/win_banner_overlay.sv
// Win banner overlay: window hit test, sprite ROM addressing and a two-stage
// pipeline that composites non-transparent ROM pixels over the background.
module win_banner_overlay
    import win_banner_overlay_pkg::*;
#(
    parameter int unsigned SCALE_LOG2   = 0,
    parameter int unsigned BLINK_FRAMES = 30,
    parameter logic [15:0] KEY_RGB      = 16'h0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          show,
    input  logic          frame_start,
    input  logic [CW-1:0] org_x,
    input  logic [CW-1:0] org_y,
    input  logic          pix_valid,
    input  logic [CW-1:0] hcount,
    input  logic [CW-1:0] vcount,
    input  logic [15:0]   bg_rgb,
    output logic [5:0]    rom_x,
    output logic [5:0]    rom_y,
    input  logic [15:0]   rom_rgb,
    output logic          out_valid,
    output logic [15:0]   out_rgb,
    output logic          active
);

    localparam logic [CW-1:0] WIN_W = win_extent(SPR_W, int'(SCALE_LOG2));
    localparam logic [CW-1:0] WIN_H = win_extent(SPR_H, int'(SCALE_LOG2));

    logic          ctrl_active_s;
    logic          ctrl_visible_s;
    logic [CW-1:0] ox_s;
    logic [CW-1:0] oy_s;

    banner_ctrl_fsm #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .show        (show),
        .frame_start (frame_start),
        .org_x       (org_x),
        .org_y       (org_y),
        .active      (ctrl_active_s),
        .visible     (ctrl_visible_s),
        .ox          (ox_s),
        .oy          (oy_s)
    );

    logic [CW:0] dx_s;
    logic [CW:0] dy_s;
    logic        hit_s;

    // Offsets carry an extra bit so a raster position left of / above the origin shows as a borrow.
    assign dx_s  = {1'b0, hcount} - {1'b0, ox_s};
    assign dy_s  = {1'b0, vcount} - {1'b0, oy_s};
    assign hit_s = pix_valid & ~dx_s[CW] & ~dy_s[CW]
                 & (dx_s[CW-1:0] < WIN_W) & (dy_s[CW-1:0] < WIN_H);

    // ROM coordinates, parked at the origin outside the window.
    always_comb begin
        rom_x = 6'd0;
        rom_y = 6'd0;
        if (hit_s) begin
            rom_x = 6'(dx_s[CW-1:0] >> SCALE_LOG2);
            rom_y = 6'(dy_s[CW-1:0] >> SCALE_LOG2);
        end else begin
            rom_x = 6'd0;
            rom_y = 6'd0;
        end
    end

    logic        v1_q, v1_d;
    logic        use1_q, use1_d;
    logic [15:0] bg1_q, bg1_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] out_rgb_q, out_rgb_d;

    // Stage 1 waits out the ROM latency; stage 2 selects sprite or background.
    always_comb begin
        v1_d        = pix_valid;
        bg1_d       = bg_rgb;
        use1_d      = hit_s & ctrl_active_s & ctrl_visible_s;
        out_valid_d = v1_q;
        out_rgb_d   = bg1_q;
        if (use1_q && (rom_rgb != KEY_RGB)) begin
            out_rgb_d = rom_rgb;
        end else begin
            out_rgb_d = bg1_q;
        end
    end

    // Pixel pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            use1_q      <= 1'b0;
            bg1_q       <= 16'h0000;
            out_valid_q <= 1'b0;
            out_rgb_q   <= 16'h0000;
        end else begin
            v1_q        <= v1_d;
            use1_q      <= use1_d;
            bg1_q       <= bg1_d;
            out_valid_q <= out_valid_d;
            out_rgb_q   <= out_rgb_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_rgb   = out_rgb_q;
    assign active    = ctrl_active_s;

endmodule

// File: tb/tb_win_banner_overlay.sv
// Self-checking bench for win_banner_overlay: two instances (x1 with 2-frame
// blink, x2 without blink) share the raster stimulus and are checked against a model.
module tb_win_banner_overlay;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        show = 1'b0;
    logic        frame_start = 1'b0;
    logic [10:0] org_x = 11'd0;
    logic [10:0] org_y = 11'd0;
    logic        pix_valid = 1'b0;
    logic [10:0] hcount = 11'd0;
    logic [10:0] vcount = 11'd0;
    logic [15:0] bg_rgb = 16'h0000;

    logic [5:0]  rom_x_a, rom_y_a, rom_x_b, rom_y_b;
    logic [15:0] rom_rgb_a = 16'h0000;
    logic [15:0] rom_rgb_b = 16'h0000;
    logic        out_valid_a, out_valid_b, active_a, active_b;
    logic [15:0] out_rgb_a, out_rgb_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    win_banner_overlay #(.SCALE_LOG2(0), .BLINK_FRAMES(2), .KEY_RGB(16'h0000)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .show(show), .frame_start(frame_start),
        .org_x(org_x), .org_y(org_y), .pix_valid(pix_valid), .hcount(hcount),
        .vcount(vcount), .bg_rgb(bg_rgb), .rom_x(rom_x_a), .rom_y(rom_y_a),
        .rom_rgb(rom_rgb_a), .out_valid(out_valid_a), .out_rgb(out_rgb_a), .active(active_a)
    );

    win_banner_overlay #(.SCALE_LOG2(1), .BLINK_FRAMES(0), .KEY_RGB(16'h0000)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .show(show), .frame_start(frame_start),
        .org_x(org_x), .org_y(org_y), .pix_valid(pix_valid), .hcount(hcount),
        .vcount(vcount), .bg_rgb(bg_rgb), .rom_x(rom_x_b), .rom_y(rom_y_b),
        .rom_rgb(rom_rgb_b), .out_valid(out_valid_b), .out_rgb(out_rgb_b), .active(active_b)
    );

    // Sprite ROM contents: one green marker, a transparent lattice, elsewhere a coordinate code.
    function automatic logic [15:0] rom_fn(input logic [5:0] x, input logic [5:0] y);
        if (x == 6'd5 && y == 6'd2) return 16'h07E0;
        if (((x ^ y) & 6'd3) == 6'd0) return 16'h0000;
        return {x, y, 4'h5};
    endfunction

    // Sprite ROMs with one registered cycle of read latency.
    always @(posedge clk) begin
        rom_rgb_a <= rom_fn(rom_x_a, rom_y_a);
        rom_rgb_b <= rom_fn(rom_x_b, rom_y_b);
    end

    // Reference model: banner mode, latched origin, frames shown since entry, output delay line.
    int          m_mode;     // 0 off, 1 waiting for frame, 2 shown
    int          m_ox, m_oy, m_k;
    int          sc[2] = '{0, 1};
    int          bf[2] = '{2, 0};
    bit          cur_v[2], p1_v[2], p2_v[2];
    logic [15:0] cur_rgb[2], p1_rgb[2], p2_rgb[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_ox = 0; m_oy = 0; m_k = 0;
        for (int i = 0; i < 2; i++) begin
            p1_v[i] = 1'b0; p2_v[i] = 1'b0; p1_rgb[i] = 16'h0; p2_rgb[i] = 16'h0;
        end
    endtask

    function automatic bit m_visible(input int i);
        if (bf[i] == 0) return 1'b1;
        return ((m_k / bf[i]) % 2) == 0;
    endfunction

    // Drive one raster cycle and check the combinational ROM address of both instances.
    task automatic apply(input bit fs, input bit pv, input int hx, input int vy, input logic [15:0] bg);
        int dx, dy, rx, ry;
        bit hit, use_it;
        logic [15:0] rom;
        frame_start = fs; pix_valid = pv;
        hcount = 11'(hx); vcount = 11'(vy); bg_rgb = bg;
        #1;
        for (int i = 0; i < 2; i++) begin
            dx = int'(hcount) - m_ox;
            dy = int'(vcount) - m_oy;
            hit = pv && dx >= 0 && dy >= 0 && dx < (64 << sc[i]) && dy < (48 << sc[i]);
            rx = hit ? (dx >> sc[i]) : 0;
            ry = hit ? (dy >> sc[i]) : 0;
            chk(i == 0 ? "rom_x_a" : "rom_x_b", i == 0 ? 32'(rom_x_a) : 32'(rom_x_b), 32'(rx));
            chk(i == 0 ? "rom_y_a" : "rom_y_b", i == 0 ? 32'(rom_y_a) : 32'(rom_y_b), 32'(ry));
            rom = rom_fn(6'(rx), 6'(ry));
            use_it = hit && m_mode == 2 && m_visible(i);
            cur_v[i] = pv;
            cur_rgb[i] = (use_it && rom != 16'h0000) ? rom : bg;
        end
    endtask

    // Advance one clock, update the model and check pipeline outputs and mode.
    task automatic clock_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            p2_v[i] = p1_v[i]; p2_rgb[i] = p1_rgb[i];
            p1_v[i] = cur_v[i]; p1_rgb[i] = cur_rgb[i];
        end
        case (m_mode)
            0: if (show) m_mode = 1;
            1: if (!show) m_mode = 0; else if (frame_start) begin m_mode = 2; m_k = 0; end
            2: if (frame_start) begin if (!show) m_mode = 0; else m_k++; end
            default: m_mode = 0;
        endcase
        if (frame_start) begin m_ox = int'(org_x); m_oy = int'(org_y); end
        chk("out_valid_a", 32'(out_valid_a), 32'(p2_v[0]));
        chk("out_rgb_a", 32'(out_rgb_a), 32'(p2_rgb[0]));
        chk("out_valid_b", 32'(out_valid_b), 32'(p2_v[1]));
        chk("out_rgb_b", 32'(out_rgb_b), 32'(p2_rgb[1]));
        chk("active_a", 32'(active_a), 32'(m_mode == 2));
        chk("active_b", 32'(active_b), 32'(m_mode == 2));
    endtask

    task automatic step(input bit fs, input bit pv, input int hx, input int vy, input logic [15:0] bg);
        apply(fs, pv, hx, vy, bg);
        clock_step();
    endtask

    initial begin
        bit exp_vis[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        int h;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid_a), 32'd0);
        chk("rst_out_rgb", 32'(out_rgb_a), 32'd0);
        chk("rst_active", 32'(active_a), 32'd0);
        rst_n = 1'b1;

        // Pass-through with the banner off.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 300 + i, 220, 16'h1234);
        chk("pass_rgb", 32'(out_rgb_a), 32'h1234);
        chk("pass_valid", 32'(out_valid_a), 32'd1);
        step(1'b0, 1'b0, 0, 0, 16'h0000);
        step(1'b0, 1'b0, 0, 0, 16'h0000);

        // Armed but not yet shown: background only.
        show = 1'b1;
        step(1'b0, 1'b0, 0, 0, 16'h0000);
        step(1'b0, 1'b1, 5, 2, 16'h5555);
        step(1'b0, 1'b0, 0, 0, 16'h0000);
        chk("armed_bg", 32'(out_rgb_a), 32'h5555);
        org_x = 11'd288; org_y = 11'd216;
        step(1'b1, 1'b0, 0, 0, 16'h0000);
        chk("enter_active", 32'(active_a), 32'd1);

        // Window addressing at x1.
        apply(1'b0, 1'b1, 293, 218, 16'hABCD);
        chk("addr_x", 32'(rom_x_a), 32'd5);
        chk("addr_y", 32'(rom_y_a), 32'd2);
        clock_step();
        step(1'b0, 1'b1, 287, 218, 16'h1111);
        chk("overlay_green", 32'(out_rgb_a), 32'h07E0);
        step(1'b0, 1'b1, 300, 240, 16'h2222);
        chk("left_miss", 32'(out_rgb_a), 32'h1111);
        apply(1'b0, 1'b1, 351, 263, 16'h3333);
        chk("corner_x", 32'(rom_x_a), 32'd63);
        chk("corner_y", 32'(rom_y_a), 32'd47);
        clock_step();
        chk("key_transparent", 32'(out_rgb_a), 32'h2222);
        apply(1'b0, 1'b1, 352, 263, 16'h4444);
        chk("right_miss_x", 32'(rom_x_a), 32'd0);
        clock_step();

        // Blink phases over successive frames.
        for (int k = 1; k < 5; k++) begin
            step(1'b1, 1'b0, 0, 0, 16'h0000);
            step(1'b0, 1'b1, 293, 218, 16'hABCD);
            step(1'b0, 1'b0, 0, 0, 16'h0000);
            chk("blink_phase", 32'(out_rgb_a), exp_vis[k] ? 32'h07E0 : 32'hABCD);
        end

        // Withdraw mid-frame: banner holds until the next frame boundary.
        show = 1'b0;
        step(1'b0, 1'b1, 293, 218, 16'hABCD);
        step(1'b0, 1'b0, 0, 0, 16'h0000);
        chk("hold_overlay", 32'(out_rgb_a), 32'h07E0);
        step(1'b1, 1'b0, 0, 0, 16'h0000);
        chk("leave_active", 32'(active_a), 32'd0);
        step(1'b0, 1'b1, 293, 218, 16'hABCD);
        step(1'b0, 1'b0, 0, 0, 16'h0000);
        chk("after_hide", 32'(out_rgb_a), 32'hABCD);

        // x2 upscale window.
        show = 1'b1;
        step(1'b0, 1'b0, 0, 0, 16'h0000);
        org_x = 11'd100; org_y = 11'd100;
        step(1'b1, 1'b0, 0, 0, 16'h0000);
        apply(1'b0, 1'b1, 103, 105, 16'h0F0F);
        chk("x2_addr_x", 32'(rom_x_b), 32'd1);
        chk("x2_addr_y", 32'(rom_y_b), 32'd2);
        clock_step();
        apply(1'b0, 1'b1, 228, 100, 16'hF0F0);
        chk("x2_edge_miss", 32'(rom_x_b), 32'd0);
        clock_step();
        step(1'b0, 1'b1, 227, 195, 16'h0101);

        // Randomized raster traffic.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 15) == 0) show = ~show;
            org_x = 11'($urandom_range(0, 700));
            org_y = 11'($urandom_range(0, 500));
            h = m_ox + int'($urandom_range(0, 150)) - 10;
            if (h < 0) h = 0;
            step($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, h,
                 m_oy + int'($urandom_range(0, 110)) - 5, 16'($urandom));
        end

        // Reset in the middle of a frame flushes the pipeline.
        show = 1'b1;
        step(1'b1, 1'b1, 300, 220, 16'h7777);
        step(1'b0, 1'b1, 301, 220, 16'h8888);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid_a), 32'd0);
        chk("midrst_active", 32'(active_a), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        show = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 290 + i, 220, 16'h9999);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
